// File: rtl/instr_queue_pkg.sv
// Shared types for the fetch/decode instruction queue.
package instr_queue_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } iq_state_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling queue: circular buffer of {pc, instr}, flush on
// taken branch with drop of one stale in-flight response, gap-free order tag.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     imem_resp,
  input  logic [31:0]              imem_rdata,
  input  logic [31:0]              resp_pc,
  input  logic                     imem_pending,
  input  logic                     flush,
  input  logic                     deq,
  output logic                     iq_valid,
  output logic [31:0]              iq_instr,
  output logic [31:0]              iq_pc,
  output logic [63:0]              iq_order,
  output logic                     iq_full,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_state_t       r_state, w_state_nxt;
  iq_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic [63:0]     r_order;

  logic w_run, w_full, w_valid, w_enq, w_deq;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);

  // flush outranks both enqueue and dequeue in the same cycle
  assign w_enq = imem_resp && w_run && !flush && (!w_full || deq);
  assign w_deq = deq && w_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush && imem_pending && !imem_resp) w_state_nxt = DISCARD;
      DISCARD: if (!flush && imem_resp)                 w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_run = (r_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_order <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) begin
        r_head  <= r_head + PW'(1);
        r_order <= r_order + 64'd1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= '{pc: resp_pc, instr: imem_rdata};
  end

  assign iq_valid = w_valid;
  assign iq_instr = w_valid ? r_mem[r_head].instr : NOP;
  assign iq_pc    = w_valid ? r_mem[r_head].pc    : 32'h0;
  assign iq_order = r_order;
  assign iq_full  = w_full;
  assign iq_count = r_count;

`ifndef SYNTHESIS
  // a response while full with no dequeue means fetch ignored iq_full
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp && w_run && !flush && w_full && !deq));
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed + randomized check of instr_queue against a queue-based model.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOPI = 32'h00000013;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] resp_pc = '0;
  logic        imem_pending = 1'b0;
  logic        flush = 1'b0;
  logic        deq = 1'b0;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic [63:0] iq_order;
  logic        iq_full;
  logic [2:0]  iq_count;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .resp_pc(resp_pc), .imem_pending(imem_pending), .flush(flush), .deq(deq),
    .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc), .iq_order(iq_order),
    .iq_full(iq_full), .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  // behavioural model
  ent_t    mq[$];
  bit      m_discard = 1'b0;
  longint  m_order = 0;
  bit      chk_en = 1'b0;
  int      n_chk = 0, n_pass = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); m_discard = 1'b0; m_order = 0;
    end else if (flush) begin
      mq.delete();
      m_discard = m_discard || (imem_pending && !imem_resp);
    end else if (m_discard) begin
      if (imem_resp) m_discard = 1'b0;
    end else begin
      bit do_enq;
      do_enq = imem_resp && (mq.size() < DEPTH || deq);
      if (deq && mq.size() > 0) begin
        void'(mq.pop_front());
        m_order++;
      end
      if (do_enq) mq.push_back('{pc: resp_pc, instr: imem_rdata});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // per-cycle compare; DUT outputs depend only on registered state
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 64'(iq_valid), 64'(mq.size() > 0));
      chk("m_count", 64'(iq_count), 64'(mq.size()));
      chk("m_full",  64'(iq_full),  64'(mq.size() == DEPTH));
      chk("m_order", iq_order, 64'(m_order));
      chk("m_instr", 64'(iq_instr), 64'(mq.size() > 0 ? mq[0].instr : NOPI));
      chk("m_pc",    64'(iq_pc),    64'(mq.size() > 0 ? mq[0].pc : 32'h0));
    end
  end

  task automatic drive(input bit rs, input bit r, input logic [31:0] pc,
                       input bit p, input bit f, input bit d);
    @(negedge clk);
    rst = rs; imem_resp = r; resp_pc = pc; imem_rdata = pc ^ 32'h5a5a0033;
    imem_pending = p; flush = f; deq = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] pc);
    drive(1'b0, 1'b1, pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(iq_valid), 64'd0);
    chk({tag, "_full"},  64'(iq_full),  64'd0);
    chk({tag, "_count"}, 64'(iq_count), 64'd0);
    chk({tag, "_instr"}, 64'(iq_instr), 64'h13);
    chk({tag, "_pc"},    64'(iq_pc),    64'd0);
    chk({tag, "_order"}, iq_order,      64'd0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    chk_en = 1'b1;
    chk_reset("rst");

    // fill to DEPTH
    for (int i = 0; i < 4; i++) resp(32'h1eceb000 + 32'(4 * i));
    idle();
    chk("fill_count", 64'(iq_count), 64'd4);
    chk("fill_full",  64'(iq_full),  64'd1);
    chk("fill_pc",    64'(iq_pc),    64'h1eceb000);
    chk("fill_instr", 64'(iq_instr), 64'(32'h1eceb000 ^ 32'h5a5a0033));
    chk("fill_order", iq_order,      64'd0);

    // enqueue + dequeue while full
    drive(1'b0, 1'b1, 32'h1eceb010, 1'b0, 1'b0, 1'b1);
    idle();
    chk("encdq_count", 64'(iq_count), 64'd4);
    chk("encdq_pc",    64'(iq_pc),    64'h1eceb004);
    chk("encdq_order", iq_order,      64'd1);
    pop(); pop(); pop();
    idle();
    chk("wrap_pc",    64'(iq_pc),    64'h1eceb010);
    chk("wrap_order", iq_order,      64'd4);
    pop();
    idle();
    chk("drain_valid", 64'(iq_valid), 64'd0);
    chk("drain_order", iq_order,      64'd5);

    // dequeue while empty is ignored
    pop();
    idle();
    chk("eDeq_valid", 64'(iq_valid), 64'd0);
    chk("eDeq_instr", 64'(iq_instr), 64'h13);
    chk("eDeq_order", iq_order,      64'd5);

    // flush with request pending drops the next response
    for (int i = 0; i < 3; i++) resp(32'h1eceb000 + 32'(4 * i));
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    resp(32'h1eceb00c);
    chk("flush_valid", 64'(iq_valid), 64'd0);
    resp(32'h1eceb100);
    chk("disc_count", 64'(iq_count), 64'd0);
    idle();
    chk("post_count", 64'(iq_count), 64'd1);
    chk("post_pc",    64'(iq_pc),    64'h1eceb100);
    chk("post_order", iq_order,      64'd5);
    pop();
    idle();
    chk("post_deq_order", iq_order, 64'd6);

    // flush and response in same cycle
    drive(1'b0, 1'b1, 32'h1eceb200, 1'b0, 1'b1, 1'b0);
    idle();
    chk("fr_count", 64'(iq_count), 64'd0);
    resp(32'h1eceb204);
    idle();
    chk("fr_next_count", 64'(iq_count), 64'd1);
    chk("fr_next_pc",    64'(iq_pc),    64'h1eceb204);
    pop();

    // reset while in DISCARD
    resp(32'h1eceb300); resp(32'h1eceb304);
    idle();
    chk("pre_rst_count", 64'(iq_count), 64'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk_reset("rstd");
    resp(32'h1eceb400);
    idle();
    chk("rstd_acc_count", 64'(iq_count), 64'd1);
    chk("rstd_acc_pc",    64'(iq_pc),    64'h1eceb400);

    // randomized traffic; fetch honours iq_full so the model never overflows
    for (int c = 0; c < 3000; c++) begin
      bit rs, r, p, f, d;
      rs = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 1) == 1);
      p  = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (r && !f && !m_discard && mq.size() == DEPTH && !d) r = 1'b0;
      rst = rs; imem_resp = r; resp_pc = $urandom; imem_rdata = $urandom;
      imem_pending = p; flush = f; deq = d;
    end
    idle();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Decoupling buffer between the fetch stage and decode in the RV32I pipeline. Captures each instruction word returned by instruction memory together with its PC, holds up to DEPTH entries, and presents the oldest entry to decode with a retirement-order tag. On a taken branch it flushes all queued entries and discards a stale in-flight memory response, so decode sees only correct-path instructions.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- imem_resp  in  1  instruction memory response valid this cycle
- imem_rdata  in  32  returned instruction word
- resp_pc  in  32  PC of the address whose response is arriving
- imem_pending  in  1  fetch has a request outstanding with no response yet
- flush  in  1  taken branch / redirect (driven by br_en)
- deq  in  1  decode consumes head entry this cycle (not stalled, no load stall)
- iq_valid  out  1  head entry valid
- iq_instr  out  32  head instruction; 32'h00000013 (NOP) when empty
- iq_pc  out  32  head PC; 0 when empty
- iq_order  out  64  order tag of head instruction
- iq_full  out  1  count == DEPTH; fetch must hold its PC
- iq_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instr}, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, separate count register.
- Enqueue when imem_resp and state RUN and not flush and (not full or deq): write {resp_pc, imem_rdata} at tail, tail++.
- Dequeue when deq and iq_valid: head++. deq while empty is ignored.
- Simultaneous enqueue+dequeue: count unchanged; legal when full.
- Enqueue while full without deq: response dropped; simulation assertion fires (fetch protocol violation).
- Order counter: 64-bit, reset 0, increments on each accepted dequeue; iq_order always equals counter value, so committed order is gap-free across flushes.
- State machine (state enum):
  - RUN: normal. On flush: clear queue (head=tail=0, count=0); if imem_pending and not imem_resp, go DISCARD, else stay RUN. A response arriving in the flush cycle is dropped.
  - DISCARD: next imem_resp is dropped, return to RUN. Another flush in DISCARD keeps queue empty and stays in DISCARD.
- flush has priority over deq and enqueue in the same cycle; deq in a flush cycle does not advance the order counter.

## Timing
- Reset values: head=tail=0, count=0, state RUN, order=0; iq_valid=0, iq_full=0, iq_count=0, iq_instr=NOP, iq_pc=0, iq_order=0.
- Enqueue-to-visible latency: 1 cycle (entry written on edge, iq_valid high in following cycle).
- Head outputs are combinational from storage at head pointer; dequeue takes effect at next edge.
- iq_full/iq_count are registered-state derived, no combinational path from imem_resp or deq.
- Flush empties queue at next edge; iq_valid low the cycle after flush.
- Reset mid-operation overrides everything, including DISCARD.

## Structure
- rv32i_types gains iq_entry_t (pc, instr) and iq_state_t (RUN, DISCARD); NOP constant belongs there.
- No sub-module; single module with pointer logic, storage array, and two-state FSM.

## Test plan
- Reset, then 4 responses pc 0x1eceb000..0x1eceb00c with deq=0 -> count 4, iq_full=1, head pc 0x1eceb000, order 0.
- From full, enqueue+deq same cycle -> count stays 4, head 0x1eceb004, order 1; next enqueued pc lands at wrapped tail 0.
- Three entries queued, flush with imem_pending=1 -> queue empty next cycle; next response (pc 0x1eceb00c) dropped; following response pc 0x1eceb100 enqueued, dequeued with order continuing (no gap).
- flush and imem_resp same cycle -> response dropped, state stays RUN, next response accepted.
- deq while empty -> iq_valid=0, iq_instr=0x00000013, order unchanged.
- rst asserted in DISCARD with 2 entries -> all outputs at reset values next cycle, next response accepted.
